exec_rv32i: RTL and testbench
=============================

# exec_rv32i

Single-cycle integer execution stage for the in-order core, the full-RV32I-integer successor to the ADDI/BNE-only stage. It sits directly after fetch. It latches one instruction per cycle and reads the register file synchronously in the same edge. In the following (X) cycle it resolves the ALU result, register writeback, branch/jump redirect and exception flags. Loads, stores, FENCE and SYSTEM are out of scope and flagged illegal.

## Interface
- NREG, 32: architectural register count; 32 = RV32I, 16 = RV32E. Any rs1/rs2/rd index >= NREG is illegal.
- RESET_DATA_ZERO, 0: when 1, reset clears every register to 0; when 0, registers are not reset except x0.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- pc_i  in  32  PC of inst_i
- inst_v_i  in  1  inst_i valid this cycle
- inst_i  in  32  instruction word
- pc_v_x  out  1  redirect fetch to pc_x (taken branch/jump)
- pc_x  out  32  redirect target
- illegal_x  out  1  X-stage instruction unsupported or uses an index >= NREG
- misalign_x  out  1  taken branch/jump target with bit 1 set
- rd_v_w  out  1  register write this cycle
- rd_w  out  5  write index
- rd_data_w  out  32  write data

## Operation
- Capture edge: if inst_v_i && !pc_v_x, latch inst_i/pc_i. inst_v_x <= inst_v_i && !pc_v_x.
  - This flushes the wrong-path instruction presented in the cycle a redirect is asserted.
- Register read: rs1/rs2 are taken from inst_i (not the latched word) and read into operand registers at the capture edge.
- Bypass: at the capture edge, record rsN == rd_w && rd_v_w. In X, the operand uses the registered copy of rd_data_w instead of the array data.
  - This is the only hazard, since writeback happens in the X cycle.
- x0: reads return 0 regardless of array or bypass. A write with rd == 0 gives rd_v_w = 0.
- Supported instructions:
  - LUI, AUIPC
  - JAL, JALR (target = (rs1+imm) & ~1)
  - BEQ/BNE/BLT/BGE/BLTU/BGEU
  - ADDI/SLTI/SLTIU/XORI/ORI/ANDI/SLLI/SRLI/SRAI
  - ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND
- Decode rules:
  - Shifts use the low 5 bits of shamt/rs2.
  - SLLI/SRLI/SRAI with inst[25] set is illegal.
  - A funct7 other than 0x00 (or 0x20 for SUB/SRA/SRAI) is illegal.
  - inst[1:0] != 2'b11 is illegal.
- Arithmetic: all operations are 32-bit modulo 2^32. SLT/BLT/BGE are signed; SLTU/BLTU/BGEU are unsigned. Immediates are sign-extended to 32 bits.
- JAL/JALR write pc+4. Branch target = pc + B-imm; JAL target = pc + J-imm.
- Exceptions:
  - Illegal or misaligned: rd_v_w = 0 and pc_v_x = 0 for that instruction; the flag is high for exactly one X cycle.
  - A misaligned JAL/JALR does not write rd.
  - A not-taken branch never raises misalign_x.
- When inst_v_x = 0, all outputs are 0 (rd_w and the data values are don't-care but driven 0).

## Timing
- Latency: an instruction presented in cycle N produces its outputs in cycle N+1.
- Throughput: 1 instruction/cycle, no stall input.
- Redirect: pc_v_x is asserted in cycle N+1. The instruction presented in N+1 is discarded. Fetch supplies the target instruction from N+2.
- Back-to-back dependency: addi x1,x0,5 in N and addi x2,x1,1 in N+1 give rd_data_w = 6 in N+2 with no bubble.
- Reset (synchronous, active-high): inst_v_x = 0, bypass flags = 0, all outputs 0 the cycle after reset is sampled. This holds even if an instruction was in X; its effects are cancelled and no write occurs.
- Register contents after reset are governed by RESET_DATA_ZERO.
- A write and a read of the same register at the same edge: the read observes the new value via bypass.

## Test plan
- ALU and writeback:
  - addi x1,x0,-1; sltiu x2,x1,1; slt x3,x1,x0 -> rd_data_w = 0xFFFFFFFF, 0, 1 in consecutive cycles; rd_w = 1, 2, 3.
  - sra/srl of 0x80000000 by 4 -> 0xF8000000 / 0x08000000.
- Branches:
  - x1 = -1, x2 = 1: blt x1,x2,+8 at pc 0x100 -> pc_v_x = 1, pc_x = 0x108. The following presented instruction is flushed (no rd_v_w next cycle).
  - bltu with the same operands -> pc_v_x = 0.
- Jumps:
  - jal x1,+0x20 at 0x40 -> pc_x = 0x60, rd_data_w = 0x44.
  - jalr x0,3(x5) with x5 = 0x200 -> pc_x = 0x202 with misalign_x = 1, pc_v_x = 0.
  - jalr x0,1(x5) -> pc_x = 0x200, pc_v_x = 1.
- Bypass and x0:
  - addi x0,x0,7 then addi x4,x0,0 -> rd_v_w = 0 for the first instruction, then x4 = 0.
  - Back-to-back dependent chain of 8 addi x1,x1,1 from x1 = 0 -> final value 8.
- Illegal:
  - sw, ecall, and slli with inst[25] = 1 -> illegal_x for one cycle, no write, no redirect.
  - NREG=16: add x17,x1,x2 -> illegal_x = 1.
- Reset mid-stream: assert reset in the same cycle a taken branch is in X -> no redirect after reset; outputs 0; the next valid instruction executes normally.

Source files
------------

// File: rtl/exec_rv32i.sv
// rtl/exec_rv32i.sv - single-cycle RV32I integer execution stage
// Latches one instruction per cycle with its register operands and resolves ALU, writeback and redirect in X.
module exec_rv32i #(
   parameter int NREG            = 32,
   parameter bit RESET_DATA_ZERO = 1'b0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc_i,
   input  logic        inst_v_i,
   input  logic [31:0] inst_i,
   output logic        pc_v_x,
   output logic [31:0] pc_x,
   output logic        illegal_x,
   output logic        misalign_x,
   output logic        rd_v_w,
   output logic [4:0]  rd_w,
   output logic [31:0] rd_data_w
);
   localparam int         AW     = $clog2(NREG);
   localparam logic [5:0] NREG_L = 6'(NREG);

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;

   logic        inst_v_q;
   logic [31:0] inst_q, pc_q, op1_q, op2_q, byp_data_q;
   logic        byp1_q, byp2_q;
   logic [31:0] rf_q [NREG];

   logic [4:0]  rs1_i, rs2_i;
   logic        capture;

   assign rs1_i   = inst_i[19:15];
   assign rs2_i   = inst_i[24:20];
   assign capture = inst_v_i && !pc_v_x;

   // Operands are read from the array at the capture edge; the bypass flag covers the write landing on that same edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         inst_v_q   <= 1'b0;
         inst_q     <= '0;
         pc_q       <= '0;
         op1_q      <= '0;
         op2_q      <= '0;
         byp1_q     <= 1'b0;
         byp2_q     <= 1'b0;
         byp_data_q <= '0;
      end else begin
         inst_v_q   <= capture;
         byp_data_q <= rd_data_w;
         if (capture) begin
            inst_q <= inst_i;
            pc_q   <= pc_i;
            op1_q  <= (rs1_i == 5'd0) ? '0 : rf_q[rs1_i[AW-1:0]];
            op2_q  <= (rs2_i == 5'd0) ? '0 : rf_q[rs2_i[AW-1:0]];
            byp1_q <= (rs1_i != 5'd0) && rd_v_w && (rs1_i == rd_w);
            byp2_q <= (rs2_i != 5'd0) && rd_v_w && (rs2_i == rd_w);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++) begin
            if (RESET_DATA_ZERO || i == 0) rf_q[i] <= '0;
         end
      end else if (rd_v_w) begin
         rf_q[rd_w[AW-1:0]] <= rd_data_w;
      end
   end

   function automatic logic [31:0] alu(input logic [2:0] f3, input logic alt, input logic sub,
                                       input logic [31:0] x, input logic [31:0] y);
      logic [31:0] r;
      case (f3)
         3'b000:  r = sub ? x - y : x + y;
         3'b001:  r = x << y[4:0];
         3'b010:  r = {31'b0, $signed(x) < $signed(y)};
         3'b011:  r = {31'b0, x < y};
         3'b100:  r = x ^ y;
         3'b101:  r = alt ? 32'($signed(x) >>> y[4:0]) : x >> y[4:0];
         3'b110:  r = x | y;
         default: r = x & y;
      endcase
      return r;
   endfunction

   logic [6:0]  opcode, f7;
   logic [2:0]  f3;
   logic [4:0]  rd, rs1, rs2;
   logic [31:0] a, b, imm_i, imm_u, imm_b, imm_j, result, target;
   logic        legal, wr, use_rs1, use_rs2, use_rd, jump, branch, cond;
   logic        ok, taken, mis, x_live;

   always_comb begin
      opcode  = inst_q[6:0];
      rd      = inst_q[11:7];
      f3      = inst_q[14:12];
      rs1     = inst_q[19:15];
      rs2     = inst_q[24:20];
      f7      = inst_q[31:25];
      a       = byp1_q ? byp_data_q : op1_q;
      b       = byp2_q ? byp_data_q : op2_q;
      imm_i   = {{20{inst_q[31]}}, inst_q[31:20]};
      imm_u   = {inst_q[31:12], 12'b0};
      imm_b   = {{19{inst_q[31]}}, inst_q[31], inst_q[7], inst_q[30:25], inst_q[11:8], 1'b0};
      imm_j   = {{11{inst_q[31]}}, inst_q[31], inst_q[19:12], inst_q[20], inst_q[30:21], 1'b0};
      legal   = 1'b0;
      wr      = 1'b0;
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
      use_rd  = 1'b0;
      jump    = 1'b0;
      branch  = 1'b0;
      result  = '0;
      target  = '0;
      case (opcode)
         OP_LUI: begin
            legal = 1'b1; wr = 1'b1; use_rd = 1'b1;
            result = imm_u;
         end
         OP_AUIPC: begin
            legal = 1'b1; wr = 1'b1; use_rd = 1'b1;
            result = pc_q + imm_u;
         end
         OP_JAL: begin
            legal = 1'b1; wr = 1'b1; use_rd = 1'b1; jump = 1'b1;
            target = pc_q + imm_j;
            result = pc_q + 32'd4;
         end
         OP_JALR: begin
            legal = (f3 == 3'b000); wr = 1'b1; use_rd = 1'b1; use_rs1 = 1'b1; jump = 1'b1;
            target = (a + imm_i) & ~32'd1;
            result = pc_q + 32'd4;
         end
         OP_BRANCH: begin
            legal = (f3 != 3'b010) && (f3 != 3'b011); use_rs1 = 1'b1; use_rs2 = 1'b1; branch = 1'b1;
            target = pc_q + imm_b;
         end
         OP_IMM: begin
            wr = 1'b1; use_rd = 1'b1; use_rs1 = 1'b1;
            if (f3 == 3'b001)      legal = (f7 == 7'h00);
            else if (f3 == 3'b101) legal = (f7 == 7'h00) || (f7 == 7'h20);
            else                   legal = 1'b1;
            result = alu(f3, f7[5], 1'b0, a, imm_i);
         end
         OP_REG: begin
            wr = 1'b1; use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
            legal = (f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'b000) || (f3 == 3'b101)));
            result = alu(f3, f7[5], f7[5], a, b);
         end
         default: legal = 1'b0;
      endcase

      case (f3)
         3'b000:  cond = (a == b);
         3'b001:  cond = (a != b);
         3'b100:  cond = $signed(a) < $signed(b);
         3'b101:  cond = $signed(a) >= $signed(b);
         3'b110:  cond = a < b;
         3'b111:  cond = a >= b;
         default: cond = 1'b0;
      endcase

      ok = legal
         && !(use_rs1 && ({1'b0, rs1} >= NREG_L))
         && !(use_rs2 && ({1'b0, rs2} >= NREG_L))
         && !(use_rd  && ({1'b0, rd}  >= NREG_L));
      taken  = jump || (branch && cond);
      mis    = ok && taken && target[1];
      // Reset cancels whatever sits in X, including its write and redirect.
      x_live = inst_v_q && !reset;
   end

   assign illegal_x  = x_live && !ok;
   assign misalign_x = x_live && mis;
   assign pc_v_x     = x_live && ok && taken && !target[1];
   assign pc_x       = (x_live && ok && taken) ? target : '0;
   assign rd_v_w     = x_live && ok && wr && !mis && (rd != 5'd0);
   assign rd_w       = rd_v_w ? rd : '0;
   assign rd_data_w  = rd_v_w ? result : '0;
endmodule

// File: tb/tb_exec_rv32i.sv
// tb/tb_exec_rv32i.sv - scoreboard bench for exec_rv32i
// Stimulus pushes hand-computed expectations tagged with their output cycle; a negedge monitor pops and compares.
module tb_exec_rv32i;
   localparam logic [6:0] OPI = 7'b0010011, OPR = 7'b0110011, LUI = 7'b0110111;
   localparam logic [6:0] AUIPC = 7'b0010111, JALR = 7'b1100111;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] pc_i, inst_i, inst16;
   logic        inst_v_i, inst_v16;
   logic        pc_v_x, illegal_x, misalign_x, rd_v_w;
   logic [31:0] pc_x, rd_data_w;
   logic [4:0]  rd_w;
   logic        pc_v16, ill16, mis16, rd_v16;
   logic [31:0] pc_x16, rd_data16;
   logic [4:0]  rd_w16;

   always #5 clk = ~clk;

   exec_rv32i #(.NREG(32), .RESET_DATA_ZERO(1'b1)) u_dut (
      .clk(clk), .reset(reset), .pc_i(pc_i), .inst_v_i(inst_v_i), .inst_i(inst_i),
      .pc_v_x(pc_v_x), .pc_x(pc_x), .illegal_x(illegal_x), .misalign_x(misalign_x),
      .rd_v_w(rd_v_w), .rd_w(rd_w), .rd_data_w(rd_data_w));

   exec_rv32i #(.NREG(16), .RESET_DATA_ZERO(1'b0)) u_dut16 (
      .clk(clk), .reset(reset), .pc_i(pc_i), .inst_v_i(inst_v16), .inst_i(inst16),
      .pc_v_x(pc_v16), .pc_x(pc_x16), .illegal_x(ill16), .misalign_x(mis16),
      .rd_v_w(rd_v16), .rd_w(rd_w16), .rd_data_w(rd_data16));

   typedef struct {
      int          cyc;
      bit          idle;
      bit          chk_pc;
      logic        pc_v, ill, mis, rd_v;
      logic [31:0] pc;
      logic [4:0]  rd;
      logic [31:0] data;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (q.size() > 0 && q[0].cyc < cyc) begin
         mon_e = q.pop_front();
         chk("missed_expectation", 32'(cyc), 32'(mon_e.cyc));
      end
      if (q.size() > 0 && q[0].cyc == cyc) begin
         mon_e = q.pop_front();
         chk("pc_v_x", 32'(pc_v_x), 32'(mon_e.pc_v));
         chk("illegal_x", 32'(illegal_x), 32'(mon_e.ill));
         chk("misalign_x", 32'(misalign_x), 32'(mon_e.mis));
         chk("rd_v_w", 32'(rd_v_w), 32'(mon_e.rd_v));
         if (mon_e.chk_pc) chk("pc_x", pc_x, mon_e.pc);
         if (mon_e.rd_v) begin
            chk("rd_w", 32'(rd_w), 32'(mon_e.rd));
            chk("rd_data_w", rd_data_w, mon_e.data);
         end
         if (mon_e.idle) begin
            chk("idle_pc_x", pc_x, 32'd0);
            chk("idle_rd_w", 32'(rd_w), 32'd0);
            chk("idle_rd_data_w", rd_data_w, 32'd0);
         end
      end
   end

   function automatic exp_t f_quiet();
      exp_t e;
      e.cyc = 0; e.idle = 1'b0; e.chk_pc = 1'b0;
      e.pc_v = 1'b0; e.ill = 1'b0; e.mis = 1'b0; e.rd_v = 1'b0;
      e.pc = '0; e.rd = '0; e.data = '0;
      return e;
   endfunction
   function automatic exp_t f_idle();
      exp_t e = f_quiet();
      e.idle = 1'b1;
      return e;
   endfunction
   function automatic exp_t f_wr(input logic [4:0] rd, input logic [31:0] data);
      exp_t e = f_quiet();
      e.rd_v = 1'b1; e.rd = rd; e.data = data;
      return e;
   endfunction
   function automatic exp_t f_br(input logic [31:0] pc);
      exp_t e = f_quiet();
      e.pc_v = 1'b1; e.chk_pc = 1'b1; e.pc = pc;
      return e;
   endfunction
   function automatic exp_t f_jal(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] data);
      exp_t e = f_wr(rd, data);
      e.pc_v = 1'b1; e.chk_pc = 1'b1; e.pc = pc;
      return e;
   endfunction
   function automatic exp_t f_ill();
      exp_t e = f_quiet();
      e.ill = 1'b1;
      return e;
   endfunction
   function automatic exp_t f_mis(input logic [31:0] pc);
      exp_t e = f_quiet();
      e.mis = 1'b1; e.chk_pc = 1'b1; e.pc = pc;
      return e;
   endfunction

   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd, input logic [6:0] op);
      return {imm, rs1, f3, rd, op};
   endfunction
   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
      return {f7, rs2, rs1, f3, rd, op};
   endfunction
   function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                         input logic [2:0] f3);
      return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
   endfunction
   function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
   endfunction
   function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] op);
      return {imm, rd, op};
   endfunction

   task automatic step(input bit v, input logic [31:0] pc, input logic [31:0] ins, input exp_t e);
      exp_t t = e;
      inst_v_i = v; pc_i = pc; inst_i = ins;
      t.cyc = cyc + 1;
      q.push_back(t);
      @(posedge clk); #1;
   endtask

   task automatic step_nc(input bit v, input logic [31:0] pc, input logic [31:0] ins);
      inst_v_i = v; pc_i = pc; inst_i = ins;
      @(posedge clk); #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; inst_v_i = 1'b0; pc_i = '0; inst_i = '0; inst16 = '0; inst_v16 = 1'b0;
      @(posedge clk); #1;
      step(1'b0, 32'h0, 32'h0, f_idle());
      step(1'b1, 32'h0, enc_i(12'h005, 5'd0, 3'b000, 5'd9, OPI), f_idle());
      reset = 1'b0;

      step(1'b1, 32'h0, enc_i(12'hFFF, 5'd0, 3'b000, 5'd1, OPI), f_wr(5'd1, 32'hFFFF_FFFF));
      step(1'b1, 32'h0, enc_i(12'h001, 5'd1, 3'b011, 5'd2, OPI), f_wr(5'd2, 32'h0));
      step(1'b1, 32'h0, enc_r(7'h00, 5'd0, 5'd1, 3'b010, 5'd3, OPR), f_wr(5'd3, 32'h1));
      step(1'b1, 32'h0, enc_u(20'h80000, 5'd5, LUI), f_wr(5'd5, 32'h8000_0000));
      step(1'b1, 32'h0, enc_i(12'h004, 5'd0, 3'b000, 5'd6, OPI), f_wr(5'd6, 32'h4));
      step(1'b1, 32'h0, enc_r(7'h20, 5'd6, 5'd5, 3'b101, 5'd7, OPR), f_wr(5'd7, 32'hF800_0000));
      step(1'b1, 32'h0, enc_r(7'h00, 5'd6, 5'd5, 3'b101, 5'd8, OPR), f_wr(5'd8, 32'h0800_0000));
      step(1'b1, 32'h0, enc_i(12'h404, 5'd5, 3'b101, 5'd9, OPI), f_wr(5'd9, 32'hF800_0000));
      step(1'b1, 32'h0, enc_r(7'h20, 5'd1, 5'd6, 3'b000, 5'd10, OPR), f_wr(5'd10, 32'h5));
      step(1'b1, 32'h300, enc_u(20'h00001, 5'd11, AUIPC), f_wr(5'd11, 32'h1300));
      step(1'b1, 32'h0, enc_i(12'h001, 5'd0, 3'b000, 5'd2, OPI), f_wr(5'd2, 32'h1));

      step(1'b1, 32'h100, enc_b(13'd8, 5'd2, 5'd1, 3'b100), f_br(32'h108));
      step(1'b1, 32'h104, enc_i(12'h009, 5'd0, 3'b000, 5'd12, OPI), f_idle());
      step(1'b1, 32'h108, enc_b(13'd8, 5'd2, 5'd1, 3'b110), f_quiet());

      step(1'b1, 32'h40, enc_j(21'h20, 5'd1), f_jal(32'h60, 5'd1, 32'h44));
      step(1'b1, 32'h44, enc_i(12'h001, 5'd0, 3'b000, 5'd13, OPI), f_idle());
      step(1'b1, 32'h60, enc_i(12'h200, 5'd0, 3'b000, 5'd5, OPI), f_wr(5'd5, 32'h200));
      step(1'b1, 32'h80, enc_i(12'h003, 5'd5, 3'b000, 5'd14, JALR), f_mis(32'h202));
      step(1'b1, 32'h84, enc_i(12'h001, 5'd5, 3'b000, 5'd0, JALR), f_br(32'h200));
      step(1'b1, 32'h88, enc_i(12'h001, 5'd0, 3'b000, 5'd13, OPI), f_idle());

      step(1'b1, 32'h200, enc_i(12'h007, 5'd0, 3'b000, 5'd0, OPI), f_quiet());
      step(1'b1, 32'h204, enc_i(12'h000, 5'd0, 3'b000, 5'd4, OPI), f_wr(5'd4, 32'h0));
      step(1'b1, 32'h208, enc_i(12'h000, 5'd14, 3'b000, 5'd15, OPI), f_wr(5'd15, 32'h0));

      step(1'b1, 32'h0, enc_i(12'h000, 5'd0, 3'b000, 5'd1, OPI), f_wr(5'd1, 32'h0));
      for (int i = 1; i <= 8; i++)
         step(1'b1, 32'h0, enc_i(12'h001, 5'd1, 3'b000, 5'd1, OPI), f_wr(5'd1, 32'(i)));

      step(1'b1, 32'h0, enc_r(7'h00, 5'd1, 5'd2, 3'b010, 5'd0, 7'b0100011), f_ill());
      step(1'b1, 32'h0, 32'h0000_0073, f_ill());
      step(1'b1, 32'h0, enc_i(12'h021, 5'd1, 3'b001, 5'd3, OPI), f_ill());
      step(1'b1, 32'h0, enc_r(7'h01, 5'd2, 5'd1, 3'b000, 5'd3, OPR), f_ill());
      step(1'b1, 32'h0, enc_i(12'h001, 5'd0, 3'b000, 5'd3, 7'b0010001), f_ill());
      step(1'b1, 32'h0, enc_i(12'h003, 5'd0, 3'b000, 5'd3, OPI), f_wr(5'd3, 32'h3));

      step_nc(1'b1, 32'h500, enc_j(21'h10, 5'd6));
      reset = 1'b1;
      step(1'b1, 32'h504, enc_i(12'h001, 5'd0, 3'b000, 5'd7, OPI), f_idle());
      reset = 1'b0;
      step(1'b1, 32'h600, enc_i(12'h055, 5'd0, 3'b000, 5'd3, OPI), f_wr(5'd3, 32'h55));
      step(1'b1, 32'h604, enc_i(12'h002, 5'd1, 3'b000, 5'd4, OPI), f_wr(5'd4, 32'h2));

      inst_v16 = 1'b1;
      inst16 = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd17, OPR);
      step(1'b0, 32'h0, 32'h0, f_idle());
      inst16 = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3, OPR);
      @(negedge clk);
      chk("nreg16_illegal", 32'(ill16), 32'd1);
      chk("nreg16_no_write", 32'(rd_v16), 32'd0);
      @(posedge clk); #1;
      inst_v16 = 1'b0;
      @(negedge clk);
      chk("nreg16_legal", 32'(ill16), 32'd0);
      @(posedge clk); #1;

      step(1'b0, 32'h0, 32'h0, f_idle());
      step(1'b0, 32'h0, 32'h0, f_idle());
      @(posedge clk); #1;
      chk("scoreboard_drained", 32'(q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
